lampfpu_issue_queue: RTL and testbench
======================================

Name: lampfpu_issue_queue

Overview:
Request buffer and issue controller that sits directly upstream of lampFPU_top. It accepts tagged FPU operation requests from the core over a valid/ready interface and stores them in a small in-order FIFO. It issues them one at a time to the FPU using the FPU's single-cycle opcode pulse protocol, then returns each result with its tag on a valid/ready response interface. It also owns flush propagation to the FPU.

Parameters:
DEPTH, 4, request FIFO entries; power of two, >=2
TAG_W, 4, width of the caller's request tag, echoed with the result

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
flush_i  in  1  drop all queued and in-flight work
req_valid_i  in  1  request present
req_ready_o  out  1  FIFO can accept (not full)
req_opcode_i  in  opcodeFPU_t  FPU opcode; FPU_IDLE requests are illegal
req_rndMode_i  in  rndModeFPU_t  rounding mode
req_op1_i  in  LAMP_INTEGER_DW  operand 1 (integer for I2F, low 16 bits for float ops)
req_op2_i  in  LAMP_FLOAT_DW  operand 2
req_tag_i  in  TAG_W  caller tag
rsp_valid_o  out  1  result held
rsp_ready_i  in  1  consumer takes result
rsp_result_o  out  LAMP_INTEGER_DW  FPU result
rsp_tag_o  out  TAG_W  tag of that result
fpu_flush_o  out  1  to lampFPU_top flush_i
fpu_padv_o  out  1  to padv_i; constant 1
fpu_opcode_o  out  opcodeFPU_t  to opcode_i
fpu_rndMode_o  out  rndModeFPU_t  to rndMode_i
fpu_op1_o  out  LAMP_INTEGER_DW  to op1_i
fpu_op2_o  out  LAMP_FLOAT_DW  to op2_i
fpu_result_i  in  LAMP_INTEGER_DW  from result_o
fpu_isResultValid_i  in  1  from isResultValid_o
fpu_isReady_i  in  1  from isReady_o

Behaviour:
- Reset: FIFO empty. State IDLE. rsp_valid_o=0. fpu_opcode_o=FPU_IDLE. fpu_flush_o=0. Operand outputs, rsp_result_o and rsp_tag_o = 0. req_ready_o=1 in the first cycle after reset.
- FIFO: registered, with wrap-around read/write pointers and a count of width clog2(DEPTH)+1. A push happens on req_valid_i && req_ready_o. req_ready_o = (count != DEPTH); it is combinational on count only. Simultaneous push and pop while full is not allowed (ready=0). While empty, a push is not visible until the next cycle.
- FSM:
  - IDLE -> ISSUE when FIFO non-empty, fpu_isReady_i=1 and rsp_valid_o=0.
  - ISSUE (1 cycle): fpu_opcode_o, rndMode and operands come from registers loaded from the FIFO head. The head is popped and its tag latched. -> WAIT.
  - WAIT: fpu_opcode_o=FPU_IDLE and operands held stable. On fpu_isResultValid_i, capture fpu_result_i and the tag into the response register, set rsp_valid_o=1, -> IDLE.
- Only one operation is outstanding at a time. Minimum latency is 3 cycles from accept to rsp_valid_o, plus the FPU pipeline latency.
- Response: rsp_valid_o stays high with stable data until rsp_ready_i. Issue blocks while rsp_valid_o=1, so there is no result overwrite. If rsp_ready_i and a pending IDLE->ISSUE condition occur in the same cycle, the response clears and ISSUE starts the following cycle.
- Flush, synchronous, with priority over everything:
  - FIFO emptied, state -> IDLE, rsp_valid_o=0.
  - fpu_flush_o is asserted for exactly the next cycle (registered).
  - Any fpu_isResultValid_i in the flush cycle, or in the cycle fpu_flush_o is high, is discarded.
  - A push that coincides with flush_i is dropped.
- Reset mid-WAIT: identical to the reset state. Any late isResultValid is ignored because state is IDLE.
- A stray fpu_isResultValid_i in IDLE or ISSUE is ignored.

Optional Feature:
LAMPFPU_ISSUE_PERF_EN
- Defined: adds ports perf_issued_o (32b) and perf_stall_o (32b), both reset to 0.
  - perf_issued_o counts ISSUE cycles.
  - perf_stall_o counts cycles with req_valid_i && !req_ready_o.
  - Both saturate at all-ones and are not cleared by flush.
- Undefined: ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- lampFPU_pkg gains issueState_t (IDLE/ISSUE/WAIT) and fpuReq_t, a packed struct of opcode, rndMode, op1, op2, tag (tag sized by a package constant LAMP_FPU_TAG_DW that is the default for TAG_W).
- One sub-module: lampfpu_req_fifo (generic packed-data FIFO: push, pop, full, empty, count, clear).

Test Plan:
- ADD, op1=0x3F80, op2=0x3F80, tag 5 -> rsp_result_o[15:0]=0x4000, rsp_tag_o=5. fpu_opcode_o is non-IDLE for exactly 1 cycle.
- I2F op1=32'd3 then MUL 0x4000*0x4000, back-to-back, rsp_ready_i=1 -> in order: 0x4040 (tag a), then 0x4080 (tag b). Second issue not before the first response is accepted.
- DEPTH=4, rsp_ready_i=0, push 6 requests -> req_ready_o=0 after 4 are stored (the first already issued, so 5 are accepted in total). One response is held stable. Release rsp_ready_i -> all 5 results return in tag order.
- flush_i during WAIT with 3 queued -> fpu_flush_o high exactly 1 cycle later. No rsp_valid_o for any of the 4. A new request afterwards completes normally.
- rst asserted in WAIT, then fpu_isResultValid_i pulses -> rsp_valid_o stays 0 and the FIFO is empty.
- LAMPFPU_ISSUE_PERF_EN defined: 10 ops with 3 backpressured request cycles -> perf_issued_o=10, perf_stall_o=3.

Source files
------------

// File: rtl/lampfpu_issue_queue_pkg.sv
// Shared types for the lampFPU issue queue: FPU opcode/rounding enums, data widths,
// issue FSM state encoding and the packed request record.
package lampfpu_issue_queue_pkg;

  localparam int LAMP_INTEGER_DW = 32;
  localparam int LAMP_FLOAT_DW   = 16;
  localparam int LAMP_FPU_TAG_DW = 4;

  typedef enum logic [3:0] {
    FPU_IDLE = 4'd0,
    FPU_I2F  = 4'd1,
    FPU_F2I  = 4'd2,
    FPU_ADD  = 4'd3,
    FPU_SUB  = 4'd4,
    FPU_MUL  = 4'd5,
    FPU_DIV  = 4'd6,
    FPU_EQ   = 4'd7,
    FPU_LT   = 4'd8,
    FPU_LE   = 4'd9
  } opcodeFPU_t;

  typedef enum logic {
    FPU_RNDMODE_NEAREST  = 1'b0,
    FPU_RNDMODE_TRUNCATE = 1'b1
  } rndModeFPU_t;

  typedef logic [1:0] issueState_t;
  localparam issueState_t STATE_IDLE  = 2'd0;
  localparam issueState_t STATE_ISSUE = 2'd1;
  localparam issueState_t STATE_WAIT  = 2'd2;

  typedef struct packed {
    opcodeFPU_t                  opcode;
    rndModeFPU_t                 rndMode;
    logic [LAMP_INTEGER_DW-1:0]  op1;
    logic [LAMP_FLOAT_DW-1:0]    op2;
    logic [LAMP_FPU_TAG_DW-1:0]  tag;
  } fpuReq_t;

endpackage

// File: rtl/lampfpu_req_fifo.sv
// Generic packed-data FIFO with wrap-around pointers, occupancy count and a
// synchronous clear that takes priority over push/pop.
module lampfpu_req_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clear,
  input  logic                       push,
  input  logic [W-1:0]               push_data,
  input  logic                       pop,
  output logic [W-1:0]               pop_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [W-1:0]       mem_r [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_r;
  logic [PTR_W-1:0]   rd_ptr_r;
  logic [CNT_W-1:0]   count_r;
  logic               do_push_s;
  logic               do_pop_s;

  assign full     = (count_r == CNT_W'(DEPTH));
  assign empty    = (count_r == CNT_W'(0));
  assign count    = count_r;
  assign pop_data = mem_r[rd_ptr_r];

  // Qualify requests so overflow/underflow can never corrupt the pointers.
  always_comb begin
    do_push_s = 1'b0;
    do_pop_s  = 1'b0;
    if (push && !full) begin
      do_push_s = 1'b1;
    end else begin
      do_push_s = 1'b0;
    end
    if (pop && !empty) begin
      do_pop_s = 1'b1;
    end else begin
      do_pop_s = 1'b0;
    end
  end

  // Pointer, count and storage update.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= PTR_W'(0);
      rd_ptr_r <= PTR_W'(0);
      count_r  <= CNT_W'(0);
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else if (clear) begin
      wr_ptr_r <= PTR_W'(0);
      rd_ptr_r <= PTR_W'(0);
      count_r  <= CNT_W'(0);
    end else begin
      if (do_push_s) begin
        mem_r[wr_ptr_r] <= push_data;
        wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/lampfpu_issue_queue.sv
// In-order request buffer and single-outstanding issue controller in front of lampFPU_top.
// Optional saturating performance counters are enabled with LAMPFPU_ISSUE_PERF_EN.
module lampfpu_issue_queue
  import lampfpu_issue_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int TAG_W = LAMP_FPU_TAG_DW
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        flush_i,
  input  logic                        req_valid_i,
  output logic                        req_ready_o,
  input  opcodeFPU_t                  req_opcode_i,
  input  rndModeFPU_t                 req_rndMode_i,
  input  logic [LAMP_INTEGER_DW-1:0]  req_op1_i,
  input  logic [LAMP_FLOAT_DW-1:0]    req_op2_i,
  input  logic [TAG_W-1:0]            req_tag_i,
  output logic                        rsp_valid_o,
  input  logic                        rsp_ready_i,
  output logic [LAMP_INTEGER_DW-1:0]  rsp_result_o,
  output logic [TAG_W-1:0]            rsp_tag_o,
  output logic                        fpu_flush_o,
  output logic                        fpu_padv_o,
  output opcodeFPU_t                  fpu_opcode_o,
  output rndModeFPU_t                 fpu_rndMode_o,
  output logic [LAMP_INTEGER_DW-1:0]  fpu_op1_o,
  output logic [LAMP_FLOAT_DW-1:0]    fpu_op2_o,
  input  logic [LAMP_INTEGER_DW-1:0]  fpu_result_i,
  input  logic                        fpu_isResultValid_i,
  input  logic                        fpu_isReady_i
`ifdef LAMPFPU_ISSUE_PERF_EN
  ,
  output logic [31:0]                 perf_issued_o,
  output logic [31:0]                 perf_stall_o
`endif
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  typedef struct packed {
    opcodeFPU_t                  opcode;
    rndModeFPU_t                 rndMode;
    logic [LAMP_INTEGER_DW-1:0]  op1;
    logic [LAMP_FLOAT_DW-1:0]    op2;
    logic [TAG_W-1:0]            tag;
  } req_t;

  req_t                        push_data_s;
  req_t                        head_s;
  logic                        push_s;
  logic                        pop_s;
  logic                        issue_go_s;
  logic                        capture_s;
  logic                        fifo_full_s;
  logic                        fifo_empty_s;
  logic [CNT_W-1:0]            fifo_count_s;

  issueState_t                 state_r;
  opcodeFPU_t                  fpu_opcode_r;
  rndModeFPU_t                 fpu_rnd_r;
  logic [LAMP_INTEGER_DW-1:0]  fpu_op1_r;
  logic [LAMP_FLOAT_DW-1:0]    fpu_op2_r;
  logic [TAG_W-1:0]            issue_tag_r;
  logic                        rsp_valid_r;
  logic [LAMP_INTEGER_DW-1:0]  rsp_result_r;
  logic [TAG_W-1:0]            rsp_tag_r;
  logic                        fpu_flush_r;

  assign req_ready_o   = (fifo_count_s != CNT_FULL);
  assign rsp_valid_o   = rsp_valid_r;
  assign rsp_result_o  = rsp_result_r;
  assign rsp_tag_o     = rsp_tag_r;
  assign fpu_flush_o   = fpu_flush_r;
  assign fpu_padv_o    = 1'b1;
  assign fpu_opcode_o  = fpu_opcode_r;
  assign fpu_rndMode_o = fpu_rnd_r;
  assign fpu_op1_o     = fpu_op1_r;
  assign fpu_op2_o     = fpu_op2_r;

  lampfpu_req_fifo #(
    .DEPTH (DEPTH),
    .W     ($bits(req_t))
  ) u_req_fifo (
    .clk       (clk),
    .rst       (rst),
    .clear     (flush_i),
    .push      (push_s),
    .push_data (push_data_s),
    .pop       (pop_s),
    .pop_data  (head_s),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s),
    .count     (fifo_count_s)
  );

  // Handshake qualification and FSM transition decode; flush suppresses all of it.
  always_comb begin
    push_data_s.opcode  = req_opcode_i;
    push_data_s.rndMode = req_rndMode_i;
    push_data_s.op1     = req_op1_i;
    push_data_s.op2     = req_op2_i;
    push_data_s.tag     = req_tag_i;
    push_s     = 1'b0;
    pop_s      = 1'b0;
    issue_go_s = 1'b0;
    capture_s  = 1'b0;
    if (req_valid_i && req_ready_o && !fifo_full_s && !flush_i) begin
      push_s = 1'b1;
    end else begin
      push_s = 1'b0;
    end
    case (state_r)
      STATE_IDLE: begin
        if (!flush_i && !fifo_empty_s && fpu_isReady_i && !rsp_valid_r) begin
          issue_go_s = 1'b1;
        end else begin
          issue_go_s = 1'b0;
        end
      end
      STATE_ISSUE: begin
        if (!flush_i) begin
          pop_s = 1'b1;
        end else begin
          pop_s = 1'b0;
        end
      end
      STATE_WAIT: begin
        // A result seen while a flush is being applied or propagated belongs to killed work.
        if (!flush_i && !fpu_flush_r && fpu_isResultValid_i) begin
          capture_s = 1'b1;
        end else begin
          capture_s = 1'b0;
        end
      end
      default: begin
        issue_go_s = 1'b0;
      end
    endcase
  end

  // Issue FSM, FPU-facing operand registers and the response holding register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= STATE_IDLE;
      fpu_opcode_r <= FPU_IDLE;
      fpu_rnd_r    <= FPU_RNDMODE_NEAREST;
      fpu_op1_r    <= '0;
      fpu_op2_r    <= '0;
      issue_tag_r  <= '0;
      rsp_valid_r  <= 1'b0;
      rsp_result_r <= '0;
      rsp_tag_r    <= '0;
      fpu_flush_r  <= 1'b0;
    end else if (flush_i) begin
      state_r      <= STATE_IDLE;
      fpu_opcode_r <= FPU_IDLE;
      rsp_valid_r  <= 1'b0;
      fpu_flush_r  <= 1'b1;
    end else begin
      fpu_flush_r <= 1'b0;
      if (rsp_valid_r && rsp_ready_i) begin
        rsp_valid_r <= 1'b0;
      end
      case (state_r)
        STATE_IDLE: begin
          if (issue_go_s) begin
            state_r      <= STATE_ISSUE;
            fpu_opcode_r <= head_s.opcode;
            fpu_rnd_r    <= head_s.rndMode;
            fpu_op1_r    <= head_s.op1;
            fpu_op2_r    <= head_s.op2;
            issue_tag_r  <= head_s.tag;
          end
        end
        STATE_ISSUE: begin
          state_r      <= STATE_WAIT;
          fpu_opcode_r <= FPU_IDLE;
        end
        STATE_WAIT: begin
          if (capture_s) begin
            state_r      <= STATE_IDLE;
            rsp_valid_r  <= 1'b1;
            rsp_result_r <= fpu_result_i;
            rsp_tag_r    <= issue_tag_r;
          end
        end
        default: begin
          state_r      <= STATE_IDLE;
          fpu_opcode_r <= FPU_IDLE;
        end
      endcase
    end
  end

`ifdef LAMPFPU_ISSUE_PERF_EN
  logic [31:0] perf_issued_r;
  logic [31:0] perf_stall_r;

  assign perf_issued_o = perf_issued_r;
  assign perf_stall_o  = perf_stall_r;

  // Saturating event counters; deliberately untouched by flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_issued_r <= 32'd0;
      perf_stall_r  <= 32'd0;
    end else begin
      if ((state_r == STATE_ISSUE) && (perf_issued_r != 32'hFFFF_FFFF)) begin
        perf_issued_r <= perf_issued_r + 32'd1;
      end
      if (req_valid_i && !req_ready_o && (perf_stall_r != 32'hFFFF_FFFF)) begin
        perf_stall_r <= perf_stall_r + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_lampfpu_issue_queue.sv
// Scoreboard bench for lampfpu_issue_queue with a small behavioural FPU model.
module tb_lampfpu_issue_queue;
  import lampfpu_issue_queue_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush_i = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  opcodeFPU_t  req_opcode = FPU_IDLE;
  rndModeFPU_t req_rnd = FPU_RNDMODE_NEAREST;
  logic [31:0] req_op1 = 32'd0;
  logic [15:0] req_op2 = 16'd0;
  logic [3:0]  req_tag = 4'd0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_result;
  logic [3:0]  rsp_tag;
  logic        fpu_flush;
  logic        fpu_padv;
  opcodeFPU_t  fpu_opcode;
  rndModeFPU_t fpu_rnd;
  logic [31:0] fpu_op1;
  logic [15:0] fpu_op2;
  logic [31:0] model_res = 32'd0;
  logic        model_valid = 1'b0;
  logic        model_busy = 1'b0;
  logic        inject_valid = 1'b0;
  int          model_cnt = 0;
  int          fpu_lat = 3;
`ifdef LAMPFPU_ISSUE_PERF_EN
  logic [31:0] perf_issued;
  logic [31:0] perf_stall;
`endif

  typedef struct packed {
    logic [31:0] res;
    logic [3:0]  tag;
  } exp_t;
  exp_t sb[$];

  int errors = 0;
  int checks = 0;
  int issue_cnt = 0;
  int rsp_cnt = 0;

  always #5 clk = ~clk;

  lampfpu_issue_queue dut (
    .clk                 (clk),
    .rst                 (rst),
    .flush_i             (flush_i),
    .req_valid_i         (req_valid),
    .req_ready_o         (req_ready),
    .req_opcode_i        (req_opcode),
    .req_rndMode_i       (req_rnd),
    .req_op1_i           (req_op1),
    .req_op2_i           (req_op2),
    .req_tag_i           (req_tag),
    .rsp_valid_o         (rsp_valid),
    .rsp_ready_i         (rsp_ready),
    .rsp_result_o        (rsp_result),
    .rsp_tag_o           (rsp_tag),
    .fpu_flush_o         (fpu_flush),
    .fpu_padv_o          (fpu_padv),
    .fpu_opcode_o        (fpu_opcode),
    .fpu_rndMode_o       (fpu_rnd),
    .fpu_op1_o           (fpu_op1),
    .fpu_op2_o           (fpu_op2),
    .fpu_result_i        (model_res),
    .fpu_isResultValid_i (model_valid | inject_valid),
    .fpu_isReady_i       (!model_busy)
`ifdef LAMPFPU_ISSUE_PERF_EN
    ,
    .perf_issued_o       (perf_issued),
    .perf_stall_o        (perf_stall)
`endif
  );

  // bfloat16 arithmetic for the few operand classes the bench uses.
  function automatic logic [31:0] fpu_model(opcodeFPU_t op, logic [31:0] a, logic [15:0] b);
    logic [31:0] sh;
    int p;
    case (op)
      FPU_I2F: begin
        p = 0;
        for (int i = 0; i < 32; i++) if (a[i]) p = i;
        sh = a << (31 - p);
        return (a == 32'd0) ? 32'd0 : {16'd0, 1'b0, 8'(127 + p), sh[30:24]};
      end
      FPU_ADD: return (a[15:0] == b) ? {16'd0, b[15], b[14:7] + 8'd1, b[6:0]} : 32'hFFFF_FFFF;
      FPU_MUL: return (a[6:0] == 7'd0 && b[6:0] == 7'd0) ?
                      {16'd0, a[15] ^ b[15], 8'(a[14:7] + b[14:7] - 8'd127), 7'd0} : 32'hFFFF_FFFF;
      default: return 32'hFFFF_FFFF;
    endcase
  endfunction

  function automatic logic [31:0] exp_i2f(int n);
    case (n)
      1: return 32'h0000_3F80;
      2: return 32'h0000_4000;
      3: return 32'h0000_4040;
      4: return 32'h0000_4080;
      5: return 32'h0000_40A0;
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  // FPU model: starts on an opcode pulse, answers after fpu_lat cycles, killed by flush/reset.
  always @(posedge clk) begin
    if (rst || fpu_flush) begin
      model_busy  <= 1'b0;
      model_valid <= 1'b0;
      model_cnt   <= 0;
    end else if (model_busy) begin
      model_valid <= (model_cnt <= 1);
      model_busy  <= (model_cnt > 1);
      model_cnt   <= model_cnt - 1;
    end else begin
      model_valid <= 1'b0;
      if (fpu_opcode != FPU_IDLE) begin
        model_busy <= 1'b1;
        model_cnt  <= fpu_lat;
        model_res  <= fpu_model(fpu_opcode, fpu_op1, fpu_op2);
      end
    end
  end

  // Response scoreboard, hold-stability and no-issue-while-response checks.
  initial begin
    logic        held = 1'b0;
    logic        held_flush = 1'b0;
    logic [31:0] held_res = 32'd0;
    logic [3:0]  held_tag = 4'd0;
    exp_t        e;
    forever begin
      @(negedge clk);
      if (rst) begin
        held = 1'b0;
      end else begin
        if (fpu_opcode != FPU_IDLE) begin
          issue_cnt++;
          checks++;
          if (rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL issue_while_rsp: rsp_valid=%0b required 0", rsp_valid);
          end
        end
        if (held && !held_flush) begin
          checks++;
          if (rsp_valid !== 1'b1 || rsp_result !== held_res || rsp_tag !== held_tag) begin
            errors++;
            $display("FAIL rsp_stable: valid=%0b res=%h tag=%h required 1 %h %h",
                     rsp_valid, rsp_result, rsp_tag, held_res, held_tag);
          end
        end
        if (rsp_valid && rsp_ready) begin
          rsp_cnt++;
          checks++;
          if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_rsp: res=%h tag=%h required none", rsp_result, rsp_tag);
          end else begin
            e = sb.pop_front();
            if (rsp_result !== e.res || rsp_tag !== e.tag) begin
              errors++;
              $display("FAIL rsp_data: res=%h tag=%h required %h %h", rsp_result, rsp_tag, e.res, e.tag);
            end
          end
        end
        held       = rsp_valid && !rsp_ready;
        held_res   = rsp_result;
        held_tag   = rsp_tag;
        held_flush = flush_i;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    flush_i = 1'b0;
    req_valid = 1'b0;
    inject_valid = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
  endtask

  task automatic send(input opcodeFPU_t op, input logic [31:0] a, input logic [15:0] b,
                      input logic [3:0] tag, input logic [31:0] res, input bit expect_rsp);
    int n = 0;
    while (!req_ready && n < 100) begin
      tick();
      n++;
    end
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL send_timeout: req_ready=%0b required 1", req_ready);
    end else begin
      req_valid = 1'b1;
      req_opcode = op;
      req_op1 = a;
      req_op2 = b;
      req_tag = tag;
      tick();
      req_valid = 1'b0;
      if (expect_rsp) sb.push_back('{res: res, tag: tag});
    end
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 300) begin
      tick();
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: pending=%0d required 0", sb.size());
    end
    repeat (3) tick();
  endtask

  task automatic wait_issue(output bit found);
    int n = 0;
    while (fpu_opcode == FPU_IDLE && n < 50) begin
      tick();
      n++;
    end
    found = (fpu_opcode != FPU_IDLE);
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL issue_timeout: opcode=%0d required non-idle", fpu_opcode);
    end
  endtask

  task automatic test_reset();
    checks += 9;
    if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_rsp_valid: got %0b required 0", rsp_valid); end
    if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_req_ready: got %0b required 1", req_ready); end
    if (fpu_opcode !== FPU_IDLE) begin errors++; $display("FAIL rst_opcode: got %0d required 0", fpu_opcode); end
    if (fpu_flush !== 1'b0) begin errors++; $display("FAIL rst_fpu_flush: got %0b required 0", fpu_flush); end
    if (fpu_padv !== 1'b1) begin errors++; $display("FAIL rst_padv: got %0b required 1", fpu_padv); end
    if (fpu_op1 !== 32'd0) begin errors++; $display("FAIL rst_op1: got %h required 0", fpu_op1); end
    if (fpu_op2 !== 16'd0) begin errors++; $display("FAIL rst_op2: got %h required 0", fpu_op2); end
    if (rsp_result !== 32'd0) begin errors++; $display("FAIL rst_result: got %h required 0", rsp_result); end
    if (rsp_tag !== 4'd0) begin errors++; $display("FAIL rst_tag: got %h required 0", rsp_tag); end
  endtask

  task automatic test_single_add();
    int i0 = issue_cnt;
    bit found;
    rsp_ready = 1'b1;
    send(FPU_ADD, 32'h0000_3F80, 16'h3F80, 4'd5, 32'h0000_4000, 1'b1);
    wait_issue(found);
    if (found) begin
      checks++;
      if (fpu_opcode !== FPU_ADD) begin errors++; $display("FAIL add_opcode: got %0d required %0d", fpu_opcode, FPU_ADD); end
      tick();
      checks += 3;
      if (fpu_opcode !== FPU_IDLE) begin errors++; $display("FAIL add_pulse: got %0d required 0", fpu_opcode); end
      if (fpu_op1 !== 32'h3F80) begin errors++; $display("FAIL add_op1_hold: got %h required 3f80", fpu_op1); end
      if (fpu_op2 !== 16'h3F80) begin errors++; $display("FAIL add_op2_hold: got %h required 3f80", fpu_op2); end
    end
    drain();
    checks++;
    if (issue_cnt - i0 != 1) begin errors++; $display("FAIL add_issue_cycles: got %0d required 1", issue_cnt - i0); end
  endtask

  task automatic test_back_to_back();
    rsp_ready = 1'b1;
    send(FPU_I2F, 32'd3, 16'h0000, 4'hA, 32'h0000_4040, 1'b1);
    send(FPU_MUL, 32'h0000_4000, 16'h4000, 4'hB, 32'h0000_4080, 1'b1);
    drain();
  endtask

  task automatic fill_and_stall(input int stall_cycles);
    rsp_ready = 1'b0;
    for (int i = 1; i <= 5; i++) send(FPU_I2F, 32'(i), 16'h0000, 4'(i), exp_i2f(i), 1'b1);
    repeat (15) tick();
    checks += 3;
    if (req_ready !== 1'b0) begin errors++; $display("FAIL full_ready: got %0b required 0", req_ready); end
    if (rsp_valid !== 1'b1) begin errors++; $display("FAIL held_valid: got %0b required 1", rsp_valid); end
    if (rsp_tag !== 4'd1) begin errors++; $display("FAIL held_tag: got %h required 1", rsp_tag); end
    req_valid = 1'b1;
    req_opcode = FPU_I2F;
    req_op1 = 32'd6;
    req_tag = 4'd6;
    for (int i = 0; i < stall_cycles; i++) begin
      tick();
      checks++;
      if (req_ready !== 1'b0) begin errors++; $display("FAIL stall_ready: got %0b required 0", req_ready); end
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    drain();
  endtask

  task automatic test_flush();
    int i0 = issue_cnt;
    int r0 = rsp_cnt;
    bit found;
    rsp_ready = 1'b1;
    fpu_lat = 12;
    send(FPU_ADD, 32'h0000_3F80, 16'h3F80, 4'd1, 32'd0, 1'b0);
    wait_issue(found);
    send(FPU_I2F, 32'd2, 16'h0000, 4'd2, 32'd0, 1'b0);
    send(FPU_I2F, 32'd3, 16'h0000, 4'd3, 32'd0, 1'b0);
    send(FPU_I2F, 32'd4, 16'h0000, 4'd4, 32'd0, 1'b0);
    flush_i = 1'b1;
    inject_valid = 1'b1;
    req_valid = 1'b1;
    req_opcode = FPU_ADD;
    req_tag = 4'hE;
    tick();
    flush_i = 1'b0;
    req_valid = 1'b0;
    checks++;
    if (fpu_flush !== 1'b1) begin errors++; $display("FAIL fpu_flush_pulse: got %0b required 1", fpu_flush); end
    tick();
    inject_valid = 1'b0;
    checks += 3;
    if (fpu_flush !== 1'b0) begin errors++; $display("FAIL fpu_flush_width: got %0b required 0", fpu_flush); end
    if (rsp_valid !== 1'b0) begin errors++; $display("FAIL flush_rsp_valid: got %0b required 0", rsp_valid); end
    if (req_ready !== 1'b1) begin errors++; $display("FAIL flush_ready: got %0b required 1", req_ready); end
    repeat (30) tick();
    checks += 2;
    if (rsp_cnt != r0) begin errors++; $display("FAIL flush_rsp_count: got %0d required 0", rsp_cnt - r0); end
    if (issue_cnt - i0 != 1) begin errors++; $display("FAIL flush_issues: got %0d required 1", issue_cnt - i0); end
    fpu_lat = 3;
    send(FPU_ADD, 32'h0000_4000, 16'h4000, 4'd9, 32'h0000_4080, 1'b1);
    drain();
  endtask

  task automatic test_stray();
    bit found;
    rsp_ready = 1'b1;
    inject_valid = 1'b1;
    tick();
    inject_valid = 1'b0;
    checks++;
    if (rsp_valid !== 1'b0) begin errors++; $display("FAIL stray_idle: got %0b required 0", rsp_valid); end
    fpu_lat = 5;
    send(FPU_I2F, 32'd5, 16'h0000, 4'd7, 32'h0000_40A0, 1'b1);
    wait_issue(found);
    inject_valid = 1'b1;
    tick();
    inject_valid = 1'b0;
    drain();
    fpu_lat = 3;
  endtask

  task automatic test_reset_wait();
    int i0;
    bit found;
    rsp_ready = 1'b1;
    fpu_lat = 8;
    send(FPU_ADD, 32'h0000_3F80, 16'h3F80, 4'd3, 32'd0, 1'b0);
    send(FPU_I2F, 32'd1, 16'h0000, 4'd4, 32'd0, 1'b0);
    wait_issue(found);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    i0 = issue_cnt;
    inject_valid = 1'b1;
    tick();
    inject_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rstwait_rsp: got %0b required 0", rsp_valid); end
    end
    repeat (16) tick();
    checks += 2;
    if (issue_cnt != i0) begin errors++; $display("FAIL rstwait_fifo_empty: issues %0d required 0", issue_cnt - i0); end
    if (fpu_op1 !== 32'd0) begin errors++; $display("FAIL rstwait_op1: got %h required 0", fpu_op1); end
    fpu_lat = 3;
  endtask

`ifdef LAMPFPU_ISSUE_PERF_EN
  task automatic test_perf();
    do_reset();
    fill_and_stall(3);
    for (int i = 1; i <= 5; i++) send(FPU_I2F, 32'(i), 16'h0000, 4'(i + 8), exp_i2f(i), 1'b1);
    drain();
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    tick();
    checks += 2;
    if (perf_issued !== 32'd10) begin errors++; $display("FAIL perf_issued: got %0d required 10", perf_issued); end
    if (perf_stall !== 32'd3) begin errors++; $display("FAIL perf_stall: got %0d required 3", perf_stall); end
  endtask
`endif

  initial begin
    do_reset();
    test_reset();
    test_single_add();
    test_back_to_back();
    fill_and_stall(3);
    test_flush();
    test_stray();
    test_reset_wait();
`ifdef LAMPFPU_ISSUE_PERF_EN
    test_perf();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
